// File: rtl/wb_queue.sv
// Writeback buffer in front of the regfile write port: FIFO of {addr, data}
// results retired one per cycle, with newest-match bypass lookup for two read ports.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  input  logic                       wb_stall,
  output logic                       we3,
  output logic [AW-1:0]              wa3,
  output logic [DW-1:0]              wd3,
  input  logic [AW-1:0]              ra1,
  input  logic [AW-1:0]              ra2,
  output logic                       byp1_hit,
  output logic                       byp2_hit,
  output logic [DW-1:0]              byp1_data,
  output logic [DW-1:0]              byp2_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic w_enq;
  logic w_deq;

  // Writes to x0 complete the handshake but never occupy a slot.
  assign in_ready = (r_count != CW'(DEPTH));
  assign w_enq    = in_valid && in_ready && (in_addr != '0);
  assign w_deq    = (r_count != '0) && !wb_stall;
  assign count    = r_count;

  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_addr[r_tail] <= in_addr;
      r_data[r_tail] <= in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + 1'b1;
      if (w_deq) r_head <= r_head + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    we3 = w_deq;
    wa3 = '0;
    wd3 = '0;
    if (w_deq) begin
      wa3 = r_addr[r_head];
      wd3 = r_data[r_head];
    end
  end

  // Walk oldest to newest so a later match overrides: newest entry wins.
  always_comb begin
    byp1_hit  = 1'b0;
    byp2_hit  = 1'b0;
    byp1_data = '0;
    byp2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < r_count) begin
        if ((ra1 != '0) && (r_addr[r_head + PW'(k)] == ra1)) begin
          byp1_hit  = 1'b1;
          byp1_data = r_data[r_head + PW'(k)];
        end
        if ((ra2 != '0) && (r_addr[r_head + PW'(k)] == ra2)) begin
          byp2_hit  = 1'b1;
          byp2_data = r_data[r_head + PW'(k)];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed stimulus, regfile writes checked against a
// scoreboard queue by an independent monitor, plus directed state checks.
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = 3;

  logic          clock    = 1'b0;
  logic          reset_n  = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr  = '0;
  logic [DW-1:0] in_data  = '0;
  logic          wb_stall = 1'b0;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] ra1      = '0;
  logic [AW-1:0] ra2      = '0;
  logic          byp1_hit;
  logic          byp2_hit;
  logic [DW-1:0] byp1_data;
  logic [DW-1:0] byp2_data;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  n_pass  = 0;
  int  n_total = 0;

  wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .wb_stall  (wb_stall),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .ra1       (ra1),
    .ra2       (ra2),
    .byp1_hit  (byp1_hit),
    .byp2_hit  (byp2_hit),
    .byp1_data (byp1_data),
    .byp2_data (byp2_data),
    .count     (count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every regfile write must be the oldest expected entry.
  always @(negedge clock) begin
    if (reset_n) begin
      if (we3) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got wa3=%0h wd3=%0h expected no write at %0t",
                   wa3, wd3, $time);
        end else begin
          mon_e = sb.pop_front();
          chk("wa3", 64'(wa3), 64'(mon_e.a));
          chk("wd3", 64'(wd3), 64'(mon_e.d));
        end
      end else begin
        chk("idle_wa3", 64'(wa3), 64'd0);
        chk("idle_wd3", 64'(wd3), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input int exp_cnt);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 40 cycles (addr %0h)", a);
    end else begin
      if (exp_cnt >= 0) chk("count_at_send", 64'(count), 64'(exp_cnt));
      tick();
      if (a != '0) sb.push_back({a, d});
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (count == '0 && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_total++;
      $display("FAIL drain_timeout: got count=%0d pending=%0d expected 0/0", count, sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ra1 = 5'd5;
    #12;
    chk("rst_count",    64'(count),     64'd0);
    chk("rst_in_ready", 64'(in_ready),  64'd1);
    chk("rst_we3",      64'(we3),       64'd0);
    chk("rst_wa3",      64'(wa3),       64'd0);
    chk("rst_wd3",      64'(wd3),       64'd0);
    chk("rst_byp1_hit", 64'(byp1_hit),  64'd0);
    chk("rst_byp1_dat", 64'(byp1_data), 64'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Single entry latency
    send(5'd5, 32'hDEADBEEF, 0);
    @(negedge clock);
    chk("t1_count1",    64'(count),     64'd1);
    chk("t1_we3",       64'(we3),       64'd1);
    chk("t1_byp1_hit",  64'(byp1_hit),  64'd1);
    chk("t1_byp1_data", 64'(byp1_data), 64'hDEADBEEF);
    tick();
    @(negedge clock);
    chk("t1_count0",    64'(count),     64'd0);
    chk("t1_we3_off",   64'(we3),       64'd0);
    chk("t1_byp1_off",  64'(byp1_hit),  64'd0);
    tick();

    // Fill under stall, producer holds the fifth entry
    wb_stall = 1'b1;
    send(5'd1, 32'h11, 0);
    send(5'd2, 32'h22, 1);
    send(5'd3, 32'h33, 2);
    send(5'd4, 32'h44, 3);
    @(negedge clock);
    chk("t2_full_count", 64'(count),    64'd4);
    chk("t2_full_rdy",   64'(in_ready), 64'd0);
    chk("t2_stall_we3",  64'(we3),      64'd0);
    tick();
    in_valid = 1'b1;
    in_addr  = 5'd6;
    in_data  = 32'h66;
    @(negedge clock);
    chk("t2_held_rdy",   64'(in_ready), 64'd0);
    chk("t2_held_count", 64'(count),    64'd4);
    tick();
    wb_stall = 1'b0;
    @(negedge clock);
    chk("t2_rel_rdy",    64'(in_ready), 64'd0);
    chk("t2_rel_we3",    64'(we3),      64'd1);
    tick();
    @(negedge clock);
    chk("t2_rdy_back",   64'(in_ready), 64'd1);
    chk("t2_count3",     64'(count),    64'd3);
    tick();
    in_valid = 1'b0;
    sb.push_back({5'd6, 32'h66});
    @(negedge clock);
    chk("t2_simul_count", 64'(count),   64'd3);
    tick();
    drain();

    // Bypass newest-wins and x0 handling under stall
    wb_stall = 1'b1;
    ra1 = 5'd7;
    ra2 = 5'd8;
    send(5'd7, 32'hA, 0);
    send(5'd7, 32'hB, 1);
    @(negedge clock);
    chk("t3_byp1_hit",  64'(byp1_hit),  64'd1);
    chk("t3_byp1_data", 64'(byp1_data), 64'hB);
    chk("t3_byp2_hit",  64'(byp2_hit),  64'd0);
    chk("t3_byp2_data", 64'(byp2_data), 64'd0);
    tick();
    send(5'd0, 32'hFFFF, 2);
    @(negedge clock);
    chk("t4_x0_count",  64'(count),     64'd2);
    tick();
    ra1 = 5'd0;
    @(negedge clock);
    chk("t4_ra0_hit",   64'(byp1_hit),  64'd0);
    chk("t4_ra0_data",  64'(byp1_data), 64'd0);
    tick();
    ra1 = 5'd7;
    wb_stall = 1'b0;
    @(negedge clock);
    chk("t3_retire_hit",  64'(byp1_hit),  64'd1);
    chk("t3_retire_data", 64'(byp1_data), 64'hB);
    tick();
    @(negedge clock);
    chk("t3_last_hit",    64'(byp1_hit),  64'd1);
    chk("t3_last_data",   64'(byp1_data), 64'hB);
    chk("t3_last_count",  64'(count),     64'd1);
    tick();
    @(negedge clock);
    chk("t3_gone_hit",    64'(byp1_hit),  64'd0);
    chk("t3_gone_data",   64'(byp1_data), 64'd0);
    chk("t3_gone_count",  64'(count),     64'd0);
    tick();

    // x0 into an empty queue
    send(5'd0, 32'hFFFF, 0);
    @(negedge clock);
    chk("t4_empty_count", 64'(count),     64'd0);
    chk("t4_empty_we3",   64'(we3),       64'd0);
    tick();

    // Back-to-back stream across pointer wrap
    for (int i = 0; i < 12; i++) send(AW'(i + 1), DW'(i), (i == 0) ? 0 : 1);
    @(negedge clock);
    chk("t5_stream_count", 64'(count),    64'd1);
    tick();
    drain();

    // Asynchronous reset with entries queued
    wb_stall = 1'b1;
    ra1 = 5'd10;
    send(5'd9,  32'h90, 0);
    send(5'd10, 32'hA0, 1);
    send(5'd11, 32'hB0, 2);
    wb_stall = 1'b0;
    @(negedge clock);
    chk("t6_pre_we3",    64'(we3),      64'd1);
    chk("t6_pre_count",  64'(count),    64'd3);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_rst_count",  64'(count),    64'd0);
    chk("t6_rst_we3",    64'(we3),      64'd0);
    chk("t6_rst_wa3",    64'(wa3),      64'd0);
    chk("t6_rst_rdy",    64'(in_ready), 64'd1);
    chk("t6_rst_byp1",   64'(byp1_hit), 64'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    send(5'd12, 32'hC0FFEE, 0);
    @(negedge clock);
    chk("t6_post_count", 64'(count),    64'd1);
    tick();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
# wb_queue

Writeback buffer that sits directly upstream of the register file write port. It accepts completed results (destination address + data) over a valid/ready handshake and buffers them in a small FIFO. Each cycle, unless stalled, it retires the oldest entry onto the regfile write port (`we3`/`wa3`/`wd3`). It also gives the read stage a bypass lookup, so operands still waiting in the queue are not read stale from the regfile.

## Interface
- `DEPTH`, 4, number of queue entries; power of two, at least 2
- `AW`, 5, register address width
- `DW`, 32, register data width

- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  producer has a result
- `in_ready`  out  1  queue can accept; equals `count != DEPTH`
- `in_addr`  in  AW  destination register
- `in_data`  in  DW  result data
- `wb_stall`  in  1  regfile write port unavailable this cycle
- `we3`  out  1  regfile write enable
- `wa3`  out  AW  regfile write address
- `wd3`  out  DW  regfile write data
- `ra1`, `ra2`  in  AW  read addresses from the operand stage
- `byp1_hit`, `byp2_hit`  out  1  a pending entry matches `ra1` / `ra2`
- `byp1_data`, `byp2_data`  out  DW  data of the newest matching entry
- `count`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage is a circular buffer of DEPTH entries {addr, data}, with `head` (oldest) and `tail` pointers, each log2(DEPTH) bits. Pointers wrap modulo DEPTH.
- Enqueue happens when `in_valid && in_ready && in_addr != 0`. The entry is written at `tail`, `tail` increments and `count` increments.
- A handshake with `in_addr == 0` completes (accepted) but is dropped. It occupies no slot and `count` is unchanged.
- Dequeue happens when `count != 0 && !wb_stall`:
  - `we3 = 1`, `wa3`/`wd3` = head entry.
  - At the clock edge, `head` increments and `count` decrements.
- When `we3 = 0`, `wa3` and `wd3` are driven to 0.
- Simultaneous enqueue and dequeue: `count` is unchanged and both pointers advance.
- `in_ready` depends only on registered `count`. When full, no enqueue happens even if a dequeue occurs in the same cycle.
- Bypass, for each port independently:
  - Search all valid entries (head through tail-1).
  - `hit = 1` if any entry's addr equals `raN` and `raN != 0`.
  - Data is taken from the newest matching entry (the one closest to `tail`).
  - Both outputs are combinational from registered state and `raN` only.
  - When there is no hit, `bypN_data = 0`.
- The head entry being written this cycle still counts as pending and is still forwarded.
- Same-cycle `in_valid` data is never forwarded (no in→byp path).
- There is no flush. `reset_n` low immediately (asynchronously) clears `count`, `head` and `tail`. All queued entries are discarded.

## Timing
- Reset values:
  - `count = 0`, `in_ready = 1`, `we3 = 0`, `wa3 = 0`, `wd3 = 0`.
  - `byp*_hit = 0`, `byp*_data = 0`.
  - Entry storage contents need not be reset.
- Latency: an entry accepted at edge N appears on `we3`/`wa3`/`wd3` in the cycle after edge N, provided the queue was empty. The regfile captures it at edge N+1 unless `wb_stall` is high.
- An entry is forwardable from the cycle after acceptance through the cycle whose closing edge retires it.
- Throughput: one enqueue and one dequeue per cycle, sustained.
- `wb_stall` held high: the head is held and `we3 = 0`. The queue fills to DEPTH, then `in_ready = 0`. `in_ready` returns to 1 one cycle after the first retiring edge.
- Reset deasserting mid-stream: the first enqueue is possible at the first rising edge with `reset_n` high.

## Test plan
- Reset then idle: `count = 0`, `in_ready = 1`, `we3 = 0`, `wa3 = 0`, `wd3 = 0`. Then enqueue {5, 0xDEADBEEF}: next cycle `we3 = 1`, `wa3 = 5`, `wd3 = 0xDEADBEEF`; the cycle after, `count = 0` and `we3 = 0`.
- Hold `wb_stall = 1` and enqueue 5 entries ({1,0x11},{2,0x22},{3,0x33},{4,0x44},{6,0x66}) at DEPTH = 4:
  - The first 4 are accepted, then `count = 4` and `in_ready = 0`; {6,0x66} is held by the producer.
  - Release the stall: writes retire in order to regs 1, 2, 3, 4, then 6. `in_ready` returns to 1 one cycle after the first retire.
- Bypass newest-wins under stall: enqueue {7,0xA}, then {7,0xB}. With `ra1 = 7`: `byp1_hit = 1` and `byp1_data = 0xB`. With `ra2 = 8`: `byp2_hit = 0` and `byp2_data = 0`. After both retire, `byp1_hit = 0`.
- x0 handling: enqueue {0, 0xFFFF} → `count` stays 0 and `we3` never asserts. With `ra1 = 0`, `byp1_hit = 0` even while other entries are pending.
- Wrap-around and simultaneous enqueue/dequeue: stream 12 back-to-back entries {i+1, i} with no stall. `count` stays at 1 after the first, and regfile writes match in order across pointer wrap. Then assert `reset_n = 0` mid-stream with 3 entries queued: `count` goes to 0 and `we3` goes to 0 immediately, before the next clock edge.
